// File: rtl/rtc_pkg.sv
// rtl/rtc_pkg.sv - shared RTC button timing constants and channel state type
package rtc_pkg;

  localparam int CLK_HZ              = 50_000_000;
  localparam int DEBOUNCE_CYCLES_DEF = CLK_HZ / 100;
  localparam int REPEAT_DELAY_DEF    = CLK_HZ / 2;
  localparam int REPEAT_PERIOD_DEF   = CLK_HZ / 5;

  typedef enum logic [1:0] {IDLE, PRESS_DEB, PRESSED, RELEASE_DEB} btn_state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: 2-FF sync, debounce FSM, press pulse
// Auto-repeat counter present only when BUTTON_AUTO_REPEAT_EN is defined.
module debounce_channel
  import rtc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clock50MHz,
  input  logic resetn,
  input  logic button_n_i,
  input  logic enable_i,
  output logic held_o,
  output logic press_pulse_o
);

  localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          sync1_q, sync2_q;
  logic          s;
  btn_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          held_q, held_d;
  logic          pulse_q, pulse_d;
  logic          accept;
  logic          rep_fire;

  // Sync flops reset to the released level so a held button re-debounces after reset.
  always_ff @(posedge clock50MHz or negedge resetn) begin
    if (!resetn) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= button_n_i;
      sync2_q <= sync1_q;
    end
  end

  assign s = ~sync2_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    held_d  = held_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (s) begin
          state_d = PRESS_DEB;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_DEB: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          held_d  = 1'b1;
          accept  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!s) begin
          state_d = RELEASE_DEB;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_DEB: begin
        if (s) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == DEB_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          held_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        held_d  = 1'b0;
      end
    endcase
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam logic [CW-1:0] REP_FIRST  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] REP_RELOAD = CW'(REPEAT_DELAY - REPEAT_PERIOD);

  logic [CW-1:0] rep_q, rep_d;

  // Reloading to DELAY-PERIOD makes every later pulse land PERIOD cycles apart.
  always_comb begin
    rep_d    = rep_q;
    rep_fire = 1'b0;
    if (!enable_i || state_d == IDLE || state_q == PRESS_DEB) begin
      rep_d = '0;
    end else if (state_q == PRESSED) begin
      if (rep_q + CNT_ONE == REP_FIRST) begin
        rep_fire = 1'b1;
        rep_d    = REP_RELOAD;
      end else begin
        rep_d = rep_q + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clock50MHz or negedge resetn) begin
    if (!resetn) rep_q <= '0;
    else         rep_q <= rep_d;
  end
`else
  assign rep_fire = 1'b0;
`endif

  assign pulse_d = (accept & enable_i) | rep_fire;

  always_ff @(posedge clock50MHz or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      held_q  <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
      pulse_q <= pulse_d;
    end
  end

  assign held_o        = held_q;
  assign press_pulse_o = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - conditions NUM_BTN raw active-low buttons for RTC time-set
// Optional auto-repeat: define BUTTON_AUTO_REPEAT_EN.
module button_conditioner
  import rtc_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic               clock50MHz,
  input  logic               resetn,
  input  logic [NUM_BTN-1:0] push_button_n,
  input  logic               enable,
  output logic [NUM_BTN-1:0] held,
  output logic [NUM_BTN-1:0] press_pulse
);

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_chan (
      .clock50MHz    (clock50MHz),
      .resetn        (resetn),
      .button_n_i    (push_button_n[g]),
      .enable_i      (enable),
      .held_o        (held[g]),
      .press_pulse_o (press_pulse[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - scoreboard bench for button_conditioner
module tb_button_conditioner;

  logic       clock50MHz = 1'b0;
  logic       resetn     = 1'b0;
  logic [3:0] push_button_n = 4'hF;
  logic       enable = 1'b1;
  logic [3:0] held;
  logic [3:0] press_pulse;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  typedef struct {
    int         at;
    logic [3:0] mask;
  } exp_t;
  exp_t sb[$];

  always #10 clock50MHz = ~clock50MHz;
  always @(posedge clock50MHz) cyc++;

  button_conditioner #(
    .NUM_BTN         (4),
    .DEBOUNCE_CYCLES (8),
    .REPEAT_DELAY    (40),
    .REPEAT_PERIOD   (16)
  ) dut (
    .clock50MHz    (clock50MHz),
    .resetn        (resetn),
    .push_button_n (push_button_n),
    .enable        (enable),
    .held          (held),
    .press_pulse   (press_pulse)
  );

  // Every cycle: a due entry must match exactly, otherwise press_pulse must be idle.
  always @(negedge clock50MHz) begin
    if (sb.size() > 0 && sb[0].at == cyc) begin
      checks++;
      if (press_pulse !== sb[0].mask) begin
        errors++;
        $display("FAIL pulse_due cyc=%0d got=%b exp=%b", cyc, press_pulse, sb[0].mask);
      end
      void'(sb.pop_front());
    end else if (press_pulse !== 4'b0000) begin
      checks++;
      errors++;
      $display("FAIL unexpected_pulse cyc=%0d got=%b exp=0000", cyc, press_pulse);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock50MHz);
  endtask

  task automatic expect_pulse(input int at, input logic [3:0] mask);
    exp_t e;
    e.at   = at;
    e.mask = mask;
    sb.push_back(e);
  endtask

  task automatic test_reset;
    tick(3);
    checks++;
    if (held !== 4'b0000) begin
      errors++; $display("FAIL reset_held got=%b exp=0000", held);
    end
    checks++;
    if (press_pulse !== 4'b0000) begin
      errors++; $display("FAIL reset_pulse got=%b exp=0000", press_pulse);
    end
    resetn = 1'b1;
    tick(5);
  endtask

  task automatic test_clean_press;
    int c;
    c = cyc;
    push_button_n[0] = 1'b0;
    expect_pulse(c + 10, 4'b0001);
    tick(9);
    checks++;
    if (held[0] !== 1'b0) begin
      errors++; $display("FAIL clean_held_early got=%b exp=0", held[0]);
    end
    tick(1);
    checks++;
    if (held !== 4'b0001) begin
      errors++; $display("FAIL clean_held_rise got=%b exp=0001", held);
    end
    tick(10);
    c = cyc;
    push_button_n[0] = 1'b1;
    tick(9);
    checks++;
    if (held[0] !== 1'b1) begin
      errors++; $display("FAIL clean_release_early got=%b exp=1", held[0]);
    end
    tick(1);
    checks++;
    if (held[0] !== 1'b0) begin
      errors++; $display("FAIL clean_release got=%b exp=0", held[0]);
    end
    tick(5);
  endtask

  task automatic test_bounce;
    int c;
    for (int i = 0; i < 10; i++) begin
      push_button_n[1] = i[0];
      tick(3);
    end
    checks++;
    if (held[1] !== 1'b0) begin
      errors++; $display("FAIL bounce_held_during got=%b exp=0", held[1]);
    end
    c = cyc;
    push_button_n[1] = 1'b0;
    expect_pulse(c + 10, 4'b0010);
    tick(10);
    checks++;
    if (held[1] !== 1'b1) begin
      errors++; $display("FAIL bounce_held got=%b exp=1", held[1]);
    end
    tick(5);
    push_button_n[1] = 1'b1;
    tick(14);
    checks++;
    if (held[1] !== 1'b0) begin
      errors++; $display("FAIL bounce_release got=%b exp=0", held[1]);
    end
  endtask

  task automatic test_enable_gate;
    int c;
    enable = 1'b0;
    push_button_n[2] = 1'b0;
    tick(10);
    checks++;
    if (held[2] !== 1'b1) begin
      errors++; $display("FAIL gate_held got=%b exp=1", held[2]);
    end
    enable = 1'b1;
    tick(15);
    checks++;
    if (held[2] !== 1'b1) begin
      errors++; $display("FAIL gate_held_enabled got=%b exp=1", held[2]);
    end
    push_button_n[2] = 1'b1;
    tick(12);
    checks++;
    if (held[2] !== 1'b0) begin
      errors++; $display("FAIL gate_release got=%b exp=0", held[2]);
    end
    c = cyc;
    push_button_n[2] = 1'b0;
    expect_pulse(c + 10, 4'b0100);
    tick(10);
    checks++;
    if (held[2] !== 1'b1) begin
      errors++; $display("FAIL gate_repress_held got=%b exp=1", held[2]);
    end
    tick(5);
    push_button_n[2] = 1'b1;
    tick(12);
  endtask

  task automatic test_simultaneous;
    int c;
    c = cyc;
    push_button_n = 4'b0110;
    expect_pulse(c + 10, 4'b1001);
    tick(10);
    checks++;
    if (held !== 4'b1001) begin
      errors++; $display("FAIL simul_held got=%b exp=1001", held);
    end
    tick(5);
    push_button_n = 4'hF;
    tick(12);
    checks++;
    if (held !== 4'b0000) begin
      errors++; $display("FAIL simul_release got=%b exp=0000", held);
    end
  endtask

  task automatic test_repeat;
    int a;
    a = cyc + 10;
    push_button_n[0] = 1'b0;
    expect_pulse(a, 4'b0001);
`ifdef BUTTON_AUTO_REPEAT_EN
    expect_pulse(a + 40, 4'b0001);
    expect_pulse(a + 56, 4'b0001);
    expect_pulse(a + 72, 4'b0001);
    expect_pulse(a + 88, 4'b0001);
`endif
    tick(10);
    checks++;
    if (held[0] !== 1'b1) begin
      errors++; $display("FAIL repeat_held got=%b exp=1", held[0]);
    end
    tick(100);
    push_button_n[0] = 1'b1;
    tick(14);
    checks++;
    if (held[0] !== 1'b0) begin
      errors++; $display("FAIL repeat_release got=%b exp=0", held[0]);
    end
  endtask

  task automatic test_async_reset;
    int c;
    push_button_n[0] = 1'b0;
    tick(5);
    #1 resetn = 1'b0;
    #1;
    checks++;
    if (held !== 4'b0000 || press_pulse !== 4'b0000) begin
      errors++; $display("FAIL rst_deb got=%b/%b exp=0000/0000", held, press_pulse);
    end
    @(negedge clock50MHz);
    resetn = 1'b1;
    c = cyc;
    expect_pulse(c + 10, 4'b0001);
    tick(10);
    checks++;
    if (held[0] !== 1'b1) begin
      errors++; $display("FAIL rst_accept_held got=%b exp=1", held[0]);
    end
    #1 resetn = 1'b0;
    #1;
    checks++;
    if (held !== 4'b0000) begin
      errors++; $display("FAIL rst_pressed_held got=%b exp=0000", held);
    end
    checks++;
    if (press_pulse !== 4'b0000) begin
      errors++; $display("FAIL rst_pressed_pulse got=%b exp=0000", press_pulse);
    end
    @(negedge clock50MHz);
    resetn = 1'b1;
    c = cyc;
    expect_pulse(c + 10, 4'b0001);
    tick(9);
    checks++;
    if (held[0] !== 1'b0) begin
      errors++; $display("FAIL rst_again_early got=%b exp=0", held[0]);
    end
    tick(1);
    checks++;
    if (held[0] !== 1'b1) begin
      errors++; $display("FAIL rst_again_held got=%b exp=1", held[0]);
    end
    tick(5);
    push_button_n[0] = 1'b1;
    tick(12);
  endtask

  task automatic test_drain;
    tick(2);
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL drain_pending got=%0d exp=0", sb.size());
    end
  endtask

  initial begin
    test_reset;
    test_clean_press;
    test_bounce;
    test_enable_gate;
    test_simultaneous;
    test_repeat;
    test_async_reset;
    test_drain;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
